// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the 5-stage MIPS core.
// Stage payload layouts and default latch widths.
package cpu_types_pkg;

  localparam int FD_W_DEF  = 64;
  localparam int DE_W_DEF  = 160;
  localparam int EM_W_DEF  = 128;
  localparam int MW_W_DEF  = 96;
  localparam int CNT_W_DEF = 32;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
  } fd_latch_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
    logic [31:0] rdat1;
    logic [31:0] rdat2;
    logic [31:0] imm;
  } de_latch_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
    logic [31:0] alu_out;
    logic [31:0] wdat;
  } em_latch_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] alu_out;
    logic [31:0] dmem;
  } mw_latch_t;

endpackage

// File: rtl/pipe_latch.sv
// One inter-stage register with valid bit.
// Flush beats enable; otherwise hold.
module pipe_latch #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         flush,
  input  logic [W-1:0] d,
  input  logic         vin,
  output logic [W-1:0] q,
  output logic         v
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
      v <= 1'b0;
    end else if (flush) begin
      q <= '0;
      v <= 1'b0;
    end else if (en) begin
      q <= d;
      v <= vin;
    end
  end

endmodule

// File: rtl/pipeline_latch_bank.sv
// IF/ID, ID/EX, EX/MEM, MEM/WB registers with valid
// chaining and saturating stall/flush/retire counters.
module pipeline_latch_bank
  import cpu_types_pkg::*;
#(
  parameter int FD_W  = FD_W_DEF,
  parameter int DE_W  = DE_W_DEF,
  parameter int EM_W  = EM_W_DEF,
  parameter int MW_W  = MW_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             FDen,
  input  logic             DEen,
  input  logic             EMen,
  input  logic             MWen,
  input  logic             FDflush,
  input  logic             DEflush,
  input  logic             EMflush,
  input  logic             MWflush,
  input  logic [FD_W-1:0]  fd_d,
  input  logic             fd_vin,
  input  logic [DE_W-1:0]  de_d,
  input  logic [EM_W-1:0]  em_d,
  input  logic [MW_W-1:0]  mw_d,
  output logic [FD_W-1:0]  fd_q,
  output logic [DE_W-1:0]  de_q,
  output logic [EM_W-1:0]  em_q,
  output logic [MW_W-1:0]  mw_q,
  output logic             fd_v,
  output logic             de_v,
  output logic             em_v,
  output logic             mw_v,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  pipe_latch #(.W(FD_W)) u_fd (
    .clk(CLK), .rst_n(nRST),
    .en(FDen), .flush(FDflush),
    .d(fd_d), .vin(fd_vin),
    .q(fd_q), .v(fd_v)
  );

  pipe_latch #(.W(DE_W)) u_de (
    .clk(CLK), .rst_n(nRST),
    .en(DEen), .flush(DEflush),
    .d(de_d), .vin(fd_v),
    .q(de_q), .v(de_v)
  );

  pipe_latch #(.W(EM_W)) u_em (
    .clk(CLK), .rst_n(nRST),
    .en(EMen), .flush(EMflush),
    .d(em_d), .vin(de_v),
    .q(em_q), .v(em_v)
  );

  pipe_latch #(.W(MW_W)) u_mw (
    .clk(CLK), .rst_n(nRST),
    .en(MWen), .flush(MWflush),
    .d(mw_d), .vin(em_v),
    .q(mw_q), .v(mw_v)
  );

  logic stall_ev;
  logic flush_ev;
  logic retire_ev;

  assign stall_ev  = !FDen && !FDflush && fd_v;
  // Only a flush that kills a live instruction counts.
  assign flush_ev  = (FDflush && fd_v) ||
                     (DEflush && de_v) ||
                     (EMflush && em_v) ||
                     (MWflush && mw_v);
  assign retire_ev = mw_v && MWen && !MWflush;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      retire_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      if (stall_ev && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_ONE;
      if (flush_ev && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_ONE;
      if (retire_ev && retire_cnt != '1)
        retire_cnt <= retire_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_latch_bank.sv
// Directed bench for pipeline_latch_bank with a
// queue of expected values drained after each step.
module tb_pipeline_latch_bank;

  localparam int CW = 4;

  logic          CLK;
  logic          nRST;
  logic          FDen, DEen, EMen, MWen;
  logic          FDflush, DEflush, EMflush, MWflush;
  logic [63:0]   fd_d;
  logic          fd_vin;
  logic [159:0]  de_d;
  logic [127:0]  em_d;
  logic [95:0]   mw_d;
  logic [63:0]   fd_q;
  logic [159:0]  de_q;
  logic [127:0]  em_q;
  logic [95:0]   mw_q;
  logic          fd_v, de_v, em_v, mw_v;
  logic          cnt_clr;
  logic [CW-1:0] stall_cnt, flush_cnt, retire_cnt;

  int checks;
  int failures;

  pipeline_latch_bank #(.CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST),
    .FDen(FDen), .DEen(DEen),
    .EMen(EMen), .MWen(MWen),
    .FDflush(FDflush), .DEflush(DEflush),
    .EMflush(EMflush), .MWflush(MWflush),
    .fd_d(fd_d), .fd_vin(fd_vin),
    .de_d(de_d), .em_d(em_d), .mw_d(mw_d),
    .fd_q(fd_q), .de_q(de_q),
    .em_q(em_q), .mw_q(mw_q),
    .fd_v(fd_v), .de_v(de_v),
    .em_v(em_v), .mw_v(mw_v),
    .cnt_clr(cnt_clr),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt),
    .retire_cnt(retire_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string        tag;
    int           sel;
    logic [159:0] val;
  } exp_t;

  exp_t sb[$];

  function automatic logic [159:0] obs(int sel);
    case (sel)
      0:  return 160'(fd_q);
      1:  return de_q;
      2:  return 160'(em_q);
      3:  return 160'(mw_q);
      4:  return 160'(fd_v);
      5:  return 160'(de_v);
      6:  return 160'(em_v);
      7:  return 160'(mw_v);
      8:  return 160'(stall_cnt);
      9:  return 160'(flush_cnt);
      10: return 160'(retire_cnt);
      default: return '0;
    endcase
  endfunction

  task automatic push(string tag, int sel,
                      logic [159:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic push_v(logic f, logic d,
                        logic e, logic m);
    push("fd_v", 4, 160'(f));
    push("de_v", 5, 160'(d));
    push("em_v", 6, 160'(e));
    push("mw_v", 7, 160'(m));
  endtask

  task automatic push_cnt(int s, int f, int r);
    push("stall_cnt", 8, 160'(s));
    push("flush_cnt", 9, 160'(f));
    push("retire_cnt", 10, 160'(r));
  endtask

  task automatic push_all_zero();
    push("fd_q", 0, '0);
    push("de_q", 1, '0);
    push("em_q", 2, '0);
    push("mw_q", 3, '0);
    push_v(0, 0, 0, 0);
    push_cnt(0, 0, 0);
  endtask

  task automatic drain();
    exp_t e;
    logic [159:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      checks++;
      assert (o === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h",
               e.tag, o, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    drain();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    nRST     = 1'b0;
    FDen = 1; DEen = 1; EMen = 1; MWen = 1;
    FDflush = 0; DEflush = 0;
    EMflush = 0; MWflush = 0;
    cnt_clr = 0;
    fd_vin  = 1;
    fd_d    = 64'hDEAD_BEEF_0000_0004;
    de_d    = 160'h5;
    em_d    = 128'h6;
    mw_d    = 96'h7;

    // Held in reset across an edge with enables high
    push_all_zero();
    tick();

    // First load right after reset release
    nRST = 1'b1;
    push("fd_q_first", 0, 160'(64'hDEAD_BEEF_0000_0004));
    push("de_q_first", 1, 160'h5);
    push("em_q_first", 2, 160'h6);
    push("mw_q_first", 3, 160'h7);
    push_v(1, 0, 0, 0);
    tick();

    // Stream: valid reaches MEM/WB on edge 4, retires on 5
    for (int i = 1; i <= 4; i++) begin
      fd_d = 64'h1000 + 64'(i);
      de_d = 160'(fd_d);
      push("fd_q_stream", 0, 160'(fd_d));
      push_v(1, 1, i >= 2, i >= 3);
      push("retire_stream", 10, 160'(i == 4));
      tick();
    end

    cnt_clr = 1;
    fd_d = 64'h1005;
    de_d = 160'(fd_d);
    push_cnt(0, 0, 0);
    push("fd_q_clr", 0, 160'h1005);
    tick();
    cnt_clr = 0;

    // Stall IF/ID and ID/EX for three cycles
    FDen = 0;
    DEen = 0;
    fd_d = 64'hBAD;
    de_d = '1;
    for (int k = 1; k <= 3; k++) begin
      push("fd_q_hold", 0, 160'h1005);
      push("de_q_hold", 1, 160'h1005);
      push("fd_v_hold", 4, 160'(1));
      push("stall_cnt", 8, 160'(k));
      push("retire_cnt", 10, 160'(k));
      tick();
    end

    // Flush beats enable on a valid IF/ID
    FDen = 1;
    DEen = 1;
    FDflush = 1;
    push("fd_q_flush", 0, '0);
    push("de_q_load", 1, '1);
    push_v(0, 1, 1, 1);
    push_cnt(3, 1, 4);
    tick();

    // Flushing an already-empty latch is not counted
    push("fd_v_reflush", 4, '0);
    push("de_v_bubble", 5, '0);
    push_cnt(3, 1, 5);
    tick();

    // All four flushes at once
    DEflush = 1;
    EMflush = 1;
    MWflush = 1;
    push("fd_q_all", 0, '0);
    push("de_q_all", 1, '0);
    push("em_q_all", 2, '0);
    push("mw_q_all", 3, '0);
    push_v(0, 0, 0, 0);
    push_cnt(3, 2, 5);
    tick();

    FDflush = 0;
    DEflush = 0;
    EMflush = 0;
    MWflush = 0;
    MWen    = 0;
    cnt_clr = 1;
    fd_d    = 64'h2000;
    push_cnt(0, 0, 0);
    push("fd_q_reload", 0, 160'h2000);
    push("fd_v_reload", 4, 160'(1));
    tick();
    cnt_clr = 0;

    // Long stall saturates the 4-bit counter at 15
    FDen = 0;
    for (int k = 1; k <= 20; k++) begin
      push("stall_sat", 8, 160'(k > 15 ? 15 : k));
      tick();
    end

    cnt_clr = 1;
    push("stall_clr", 8, '0);
    tick();
    cnt_clr = 0;
    push("stall_after_clr", 8, 160'(1));
    push("fd_q_still", 0, 160'h2000);
    tick();

    // Asynchronous reset between edges
    #3;
    nRST = 1'b0;
    #1;
    push_all_zero();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_latch_bank.md
Name: pipeline_latch_bank

Overview:
- Owns the four inter-stage pipeline registers of the 5-stage MIPS datapath: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Consumes the per-latch enable and flush controls produced by the hazard unit and applies them to each register's payload and valid bit.
- Keeps saturating performance counters for stall, flush and retire events, which the system/debug path reads.

Parameters:
- FD_W, 64, IF/ID payload width in bits (instr + npc).
- DE_W, 160, ID/EX payload width.
- EM_W, 128, EX/MEM payload width.
- MW_W, 96, MEM/WB payload width.
- CNT_W, 32, width of each performance counter.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- nRST  in  1  asynchronous active-low reset.
- FDen, DEen, EMen, MWen  in  1 each  per-latch load enable from the hazard unit.
- FDflush, DEflush, EMflush, MWflush  in  1 each  per-latch flush from the hazard unit.
- fd_d  in  FD_W  IF/ID next payload.
- fd_vin  in  1  IF/ID next valid.
- de_d  in  DE_W  ID/EX next payload.
- em_d  in  EM_W  EX/MEM next payload.
- mw_d  in  MW_W  MEM/WB next payload.
- fd_q, de_q, em_q, mw_q  out  FD_W/DE_W/EM_W/MW_W  registered payloads.
- fd_v, de_v, em_v, mw_v  out  1 each  registered valid bits.
- cnt_clr  in  1  synchronous clear of all counters.
- stall_cnt, flush_cnt, retire_cnt  out  CNT_W each  performance counters.

Behaviour:
- Clock and reset: one clock, CLK; reset nRST is asynchronous, active-low.
- Reset values: every payload output 0, every valid output 0, every counter 0.
- Per-latch update, priority flush > enable > hold:
  - flush=1: payload <= 0, valid <= 0, regardless of enable.
  - en=1 and flush=0: payload <= d. Valid comes from the upstream latch (de_v <= fd_v, em_v <= de_v, mw_v <= em_v); fd_v <= fd_vin.
  - en=0 and flush=0: payload and valid hold.
- Latency: exactly one cycle from d to q when en=1; no combinational path from any input to any q or v output.
- Bubble propagation: if an upstream latch holds (en=0) while the downstream latch loads, the downstream latch captures the upstream q with its valid unchanged, so a stalled instruction is duplicated. The hazard unit prevents this by flushing the downstream latch; this block does not guard against it.
- stall_cnt: +1 on any cycle where FDen=0 and FDflush=0 and fd_v=1.
- flush_cnt: +1 on any cycle where at least one flush is asserted and the latch being flushed has valid=1. At most +1 per cycle.
- retire_cnt: +1 on any cycle where mw_v=1 and MWen=1 and MWflush=0.
- Counter arithmetic: unsigned, saturating at 2^CNT_W-1; no wrap-around.
- cnt_clr=1: all counters <= 0 on that edge; any increment in the same cycle is discarded.
- Reset asserted mid-operation clears all state immediately (asynchronously). First load occurs on the first rising edge after nRST deasserts.
- All four flushes asserted together: every latch empties in one cycle; flush_cnt increments by 1 if any flushed latch was valid.

Decomposition:
- cpu_types_pkg: add the stage payload typedefs (fd_latch_t, de_latch_t, em_latch_t, mw_latch_t) as packed structs, plus the default width constants.
- Sub-module pipe_latch (parameter W): one register with en/flush/valid, behaviour as above. Instantiated four times; this block adds the valid chaining and the counters.

Test Plan:
- Reset: nRST low while all enables are 1 and fd_d=64'hDEAD_BEEF_0000_0004 -> all q=0, all v=0, counters 0. Release nRST: fd_q=64'hDEAD_BEEF_0000_0004 and fd_v=1 one edge later.
- Stream: all en=1, no flush, fd_vin=1 for 4 cycles -> mw_v=1 on the 4th edge; retire_cnt=1 after the 5th edge.
- Stall: FDen=0 and DEen=0 for 3 cycles with fd_v=1 -> fd_q and de_q held constant; stall_cnt=3.
- Flush priority: FDen=1, FDflush=1, fd_d=nonzero -> fd_q=0, fd_v=0; flush_cnt +1 only when fd_v was 1.
- Saturation: CNT_W=4, hold a stall for 20 cycles -> stall_cnt stops at 15. Then cnt_clr=1 while still stalling -> stall_cnt=0 on that edge, 1 on the next.
- Async reset mid-stream: drop nRST between edges -> all outputs 0 before the next CLK edge.
